sprite_draw_arbiter: RTL and testbench
======================================

Name: sprite_draw_arbiter

Overview:
Shares the single VGA pixel-write port between several sprite FSMs: the player ship, the enemy row and the bullets.
- Each requester asks to paint one SPR_W x SPR_H sprite at a base (x, y) in one colour.
- The arbiter grants requesters round-robin and walks the sprite's pixels in raster order, one per clock.
- It drives vga_x / vga_y / vga_colour / vga_plot straight into the VGA adapter.
- Erasing a sprite is a draw request with colour 0, issued by the requester.

Parameters:
- N_REQ, 3, number of requesters (index 0 = player, 1 = enemies, 2 = bullets).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COL_W, 3, colour width.
- SPR_W, 2, sprite width in pixels (x offsets 0..SPR_W-1).
- SPR_H, 3, sprite height in pixels (y offsets 0..SPR_H-1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester draw request, level; held until grant.
- req_x  in  N_REQ*X_W  packed base x, slice i belongs to requester i.
- req_y  in  N_REQ*Y_W  packed base y.
- req_colour  in  N_REQ*COL_W  packed colour.
- grant  out  N_REQ  one-hot, 1-cycle pulse; request accepted and operands latched.
- done  out  N_REQ  one-hot, 1-cycle pulse; last pixel of that sprite written.
- busy  out  1  high in every state except IDLE.
- vga_x  out  X_W  pixel x.
- vga_y  out  Y_W  pixel y.
- vga_colour  out  COL_W  pixel colour.
- vga_plot  out  1  write enable to the VGA adapter.

Behaviour:
- All outputs are registered.
- Reset (asynchronous assert, synchronous release): state=IDLE, rr_ptr=0, grant=0, done=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- FSM states:
  - IDLE: if any req bit is set, select winner w = first set bit searching upward from rr_ptr with wrap-around. On the next edge: latch req_x[w], req_y[w], req_colour[w]; pulse grant[w]; set ox=oy=0; go to DRAW. If no req is set, stay in IDLE.
  - DRAW: vga_plot=1, vga_x=base_x+ox, vga_y=base_y+oy, vga_colour=latched colour.
    - Advance ox each cycle. When ox=SPR_W-1, reset ox to 0 and increment oy.
    - After the pixel with ox=SPR_W-1, oy=SPR_H-1, go to DONE.
  - DONE: vga_plot=0; pulse done[w]; rr_ptr <= (w+1) mod N_REQ; go to IDLE.
- Timing: with defaults, grant is seen on the cycle after req is sampled. Then 6 plot cycles, then 1 DONE cycle. Cycles from IDLE to IDLE are SPR_W*SPR_H+2 = 8.
- Handshake: the requester holds req and its operands stable until it sees grant, then drops req. If req[w] is still high in the IDLE after DONE, it counts as a new request; round-robin still favours the other requesters first.
- Coordinate arithmetic is unsigned and truncated to X_W / Y_W. Off-screen wrap-around is not clipped.
- Simultaneous requests: exactly one is granted, the rest wait. No requester is starved: with N_REQ requesters continuously active, each is granted within N_REQ grants.
- Changes to req or operands during DRAW have no effect on the sprite being drawn.
- Reset mid-draw: the sprite is abandoned immediately, no done pulse is issued, and vga_plot drops asynchronously.
- An invalid state encoding recovers to IDLE.

Decomposition:
- Package sprite_draw_pkg holds:
  - state encoding constants: IDLE, DRAW, DONE;
  - default sprite dimensions SPR_W=2, SPR_H=3;
  - requester index constants: REQ_PLAYER=0, REQ_ENEMY=1, REQ_BULLET=2.
- Sub-module rr_arbiter: combinational rotating-priority select. Inputs are req and rr_ptr; outputs are a one-hot winner and a valid flag. It is reusable by the bullet pool.

Test Plan:
- Reset, then req[0]=1 with x=10, y=20, colour=3 → grant[0] on the next cycle. Then 6 plot cycles at (10,20),(11,20),(10,21),(11,21),(10,22),(11,22), each with colour 3. Then done[0]; busy low after 8 cycles.
- req=3'b111 all held from reset → grants occur in order 0,1,2,0. Each sprite is written completely before the next grant.
- Requester 1 changes req_x during DRAW → the plotted pixels still use the latched x, and no grant[1] is re-issued until DONE.
- x=255, y=127 → second column wraps to x=0 and rows wrap to y=0,1; there is no hang and the plot count is still 6.
- reset_n pulsed low during the 3rd plot cycle → vga_plot and busy drop immediately with no done pulse. After release, a pending req[2] is granted with rr_ptr back at 0.
- req[2] held continuously while req[0] pulses repeatedly → grant[2] appears no later than every second grant.

Source files
------------

// File: rtl/sprite_draw_pkg.sv
// Shared encodings for the sprite draw arbiter: FSM states, default sprite
// dimensions and requester slot indices.
package sprite_draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned SPR_W_DEF = 2;
  localparam int unsigned SPR_H_DEF = 3;

  typedef enum int unsigned {
    REQ_PLAYER = 0,
    REQ_ENEMY  = 1,
    REQ_BULLET = 2
  } req_idx_t;

endpackage

// File: rtl/sprite_draw_arbiter_rr.sv
// Combinational rotating-priority select: first set request at or above
// rr_ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  int unsigned      sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = 32'(rr_ptr) + i;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = PTR_W'(sum);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_arbiter.sv
// Shares the VGA pixel-write port between sprite requesters: round-robin
// grant, then walks the granted sprite in raster order, one pixel per clock.
module sprite_draw_arbiter
  import sprite_draw_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 7,
  parameter int unsigned COL_W = 3,
  parameter int unsigned SPR_W = SPR_W_DEF,
  parameter int unsigned SPR_H = SPR_H_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*X_W-1:0]   req_x,
  input  logic [N_REQ*Y_W-1:0]   req_y,
  input  logic [N_REQ*COL_W-1:0] req_colour,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [COL_W-1:0]       vga_colour,
  output logic                   vga_plot
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned OX_W  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned OY_W  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt, win_idx, win_idx_nxt, arb_idx;
  logic [N_REQ-1:0]   arb_win, win_oh, win_oh_nxt, grant_nxt, done_nxt;
  logic               arb_valid, busy_nxt, plot_nxt;
  logic [OX_W-1:0]    ox, ox_nxt;
  logic [OY_W-1:0]    oy, oy_nxt;
  logic [X_W-1:0]     base_x, base_x_nxt, vga_x_nxt;
  logic [Y_W-1:0]     base_y, base_y_nxt, vga_y_nxt;
  logic [COL_W-1:0]   colour_nxt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (arb_win),
    .valid  (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      if (arb_win[i]) arb_idx = PTR_W'(i);
  end

  // Output registers hold the pixel currently on the bus, so ox/oy track that
  // pixel and the next one is computed from them.
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    win_idx_nxt = win_idx;
    win_oh_nxt  = win_oh;
    ox_nxt      = ox;
    oy_nxt      = oy;
    base_x_nxt  = base_x;
    base_y_nxt  = base_y;
    grant_nxt   = '0;
    done_nxt    = '0;
    plot_nxt    = 1'b0;
    vga_x_nxt   = vga_x;
    vga_y_nxt   = vga_y;
    colour_nxt  = vga_colour;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          state_nxt   = DRAW;
          win_idx_nxt = arb_idx;
          win_oh_nxt  = arb_win;
          grant_nxt   = arb_win;
          base_x_nxt  = req_x[arb_idx*X_W +: X_W];
          base_y_nxt  = req_y[arb_idx*Y_W +: Y_W];
          colour_nxt  = req_colour[arb_idx*COL_W +: COL_W];
          ox_nxt      = '0;
          oy_nxt      = '0;
          plot_nxt    = 1'b1;
          vga_x_nxt   = base_x_nxt;
          vga_y_nxt   = base_y_nxt;
        end
      end
      DRAW: begin
        if (ox == OX_W'(SPR_W - 1) && oy == OY_W'(SPR_H - 1)) begin
          state_nxt  = DONE;
          done_nxt   = win_oh;
          rr_ptr_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end else begin
          plot_nxt = 1'b1;
          if (ox == OX_W'(SPR_W - 1)) begin
            ox_nxt = '0;
            oy_nxt = oy + 1'b1;
          end else begin
            ox_nxt = ox + 1'b1;
          end
          vga_x_nxt = base_x + X_W'(ox_nxt);
          vga_y_nxt = base_y + Y_W'(oy_nxt);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_idx    <= '0;
      win_oh     <= '0;
      ox         <= '0;
      oy         <= '0;
      base_x     <= '0;
      base_y     <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      win_idx    <= win_idx_nxt;
      win_oh     <= win_oh_nxt;
      ox         <= ox_nxt;
      oy         <= oy_nxt;
      base_x     <= base_x_nxt;
      base_y     <= base_y_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
      vga_plot   <= plot_nxt;
      vga_x      <= vga_x_nxt;
      vga_y      <= vga_y_nxt;
      vga_colour <= colour_nxt;
    end
  end

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Scoreboard bench for sprite_draw_arbiter: stimulus queues expected grants,
// pixels and done pulses; a negedge monitor pops and compares them.
module tb_sprite_draw_arbiter;
  import sprite_draw_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] req_x = '0;
  logic [20:0] req_y = '0;
  logic [8:0]  req_colour = '0;
  logic [2:0]  grant, done;
  logic        busy, vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;

  int checks = 0;
  int errors = 0;
  int plot_cnt = 0;
  int cnt;

  logic [2:0]  exp_grant[$];
  logic [2:0]  exp_done[$];
  logic [17:0] exp_pix[$];

  sprite_draw_arbiter #(
    .N_REQ (3),
    .X_W   (8),
    .Y_W   (7),
    .COL_W (3),
    .SPR_W (2),
    .SPR_H (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Raster order: x offset fastest; coordinates truncate to bus width.
  function automatic void push_sprite(input int idx, input logic [7:0] x,
                                      input logic [6:0] y, input logic [2:0] c);
    logic [2:0] oh;
    oh = 3'b001 << idx;
    exp_grant.push_back(oh);
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 2; dx++)
        exp_pix.push_back({8'(32'(x) + dx), 7'(32'(y) + dy), c});
    exp_done.push_back(oh);
  endfunction

  task automatic set_req(input int i, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c);
    req_x[i*8 +: 8]      = x;
    req_y[i*7 +: 7]      = y;
    req_colour[i*3 +: 3] = c;
    req[i]               = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!grant[i] && n < 60);
    chk($sformatf("grant_seen%0d", i), 32'(grant[i]), 32'd1);
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[i] && n < 60);
    chk($sformatf("done_seen%0d", i), 32'(done[i]), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({grant, done, busy, vga_plot, vga_x, vga_y, vga_colour}), 32'd0);
    exp_grant.delete();
    exp_done.delete();
    exp_pix.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [17:0] ep;
    logic [2:0]  eo;
    if (reset_n) begin
      if (vga_plot) begin
        plot_cnt++;
        if (exp_pix.size() == 0) chk("pixel_expected", 32'(exp_pix.size()), 32'd1);
        else begin
          ep = exp_pix.pop_front();
          chk("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(ep));
        end
      end
      if (grant != '0) begin
        if (exp_grant.size() == 0) chk("grant_expected", 32'(grant), 32'd0);
        else begin
          eo = exp_grant.pop_front();
          chk("grant", 32'(grant), 32'(eo));
        end
      end
      if (done != '0) begin
        if (exp_done.size() == 0) chk("done_expected", 32'(done), 32'd0);
        else begin
          eo = exp_done.pop_front();
          chk("done", 32'(done), 32'(eo));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Single player sprite with full timing check
    do_reset();
    plot_cnt = 0;
    push_sprite(REQ_PLAYER, 8'd10, 7'd20, 3'd3);
    set_req(REQ_PLAYER, 8'd10, 7'd20, 3'd3);
    @(negedge clk);
    cnt = 1;
    chk("grant_latency", 32'(grant), 32'b001);
    req[0] = 1'b0;
    while (busy && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    chk("idle_to_idle_cycles", 32'(cnt), 32'd8);
    chk("plot_count_t1", 32'(plot_cnt), 32'd6);

    // All three held from reset: order 0,1,2,0
    do_reset();
    push_sprite(0, 8'd10, 7'd20, 3'd3);
    push_sprite(1, 8'd40, 7'd50, 3'd5);
    push_sprite(2, 8'd100, 7'd60, 3'd7);
    push_sprite(0, 8'd10, 7'd20, 3'd3);
    set_req(0, 8'd10, 7'd20, 3'd3);
    set_req(1, 8'd40, 7'd50, 3'd5);
    set_req(2, 8'd100, 7'd60, 3'd7);
    wait_grant(0);
    wait_grant(1);
    wait_grant(2);
    wait_grant(0);
    req = '0;
    wait_done(0);

    // Operand change during DRAW is ignored
    plot_cnt = 0;
    push_sprite(REQ_ENEMY, 8'd30, 7'd5, 3'd2);
    set_req(REQ_ENEMY, 8'd30, 7'd5, 3'd2);
    wait_grant(1);
    req_x[8 +: 8] = 8'd200;
    req_y[7 +: 7] = 7'd99;
    repeat (3) @(negedge clk);
    req[1] = 1'b0;
    wait_done(1);
    chk("plot_count_t3", 32'(plot_cnt), 32'd6);

    // Coordinate wrap at the screen corner
    @(negedge clk);
    plot_cnt = 0;
    push_sprite(0, 8'd255, 7'd127, 3'd1);
    set_req(0, 8'd255, 7'd127, 3'd1);
    wait_grant(0);
    req[0] = 1'b0;
    wait_done(0);
    chk("plot_count_wrap", 32'(plot_cnt), 32'd6);

    // Reset during the third plot cycle
    @(negedge clk);
    push_sprite(0, 8'd5, 7'd5, 3'd4);
    set_req(0, 8'd5, 7'd5, 3'd4);
    wait_grant(0);
    req[0] = 1'b0;
    set_req(REQ_BULLET, 8'd60, 7'd30, 3'd6);
    repeat (2) @(negedge clk);
    chk("third_plot_active", 32'(vga_plot), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_draw", 32'({vga_plot, busy, done}), 32'd0);
    exp_grant.delete();
    exp_done.delete();
    exp_pix.delete();
    push_sprite(REQ_BULLET, 8'd60, 7'd30, 3'd6);
    @(negedge clk);
    reset_n = 1'b1;
    wait_grant(2);
    req[2] = 1'b0;
    wait_done(2);

    // Bullet held while player pulses: grants 0,2,0,2
    @(negedge clk);
    push_sprite(0, 8'd20, 7'd10, 3'd1);
    push_sprite(2, 8'd80, 7'd40, 3'd5);
    push_sprite(0, 8'd20, 7'd10, 3'd1);
    push_sprite(2, 8'd80, 7'd40, 3'd5);
    set_req(0, 8'd20, 7'd10, 3'd1);
    set_req(2, 8'd80, 7'd40, 3'd5);
    wait_grant(0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    req[0] = 1'b1;
    wait_grant(2);
    wait_grant(0);
    req[0] = 1'b0;
    wait_grant(2);
    req[2] = 1'b0;
    wait_done(2);

    cnt = 0;
    while ((exp_pix.size() + exp_grant.size() + exp_done.size()) != 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("scoreboard_drained", 32'(exp_pix.size() + exp_grant.size() + exp_done.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("final_idle", 32'({busy, vga_plot}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
